// File: rtl/vsdserializer_pkg.sv
// Shared types and helpers for the serializer front-end arbiter.
//   state_t    : FSM encoding (IDLE / LOAD / SHIFT / GAP)
//   WORD_W_DEF : default serializer word width
//   cnt_width  : width needed for the bit and gap counters
package vsdserializer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   localparam int WORD_W_DEF = 10;

   // Both counters share one width: bit_cnt reaches WORD_W-1, gap_cnt reaches GAP_CYCLES-1.
   function automatic int cnt_width(input int word_w, input int gap_cycles);
      int span;
      span = (word_w > gap_cycles) ? word_w : gap_cycles;
      return (span > 1) ? $clog2(span) : 1;
   endfunction

endpackage

// File: rtl/vsd_rr_arbiter.sv
// Combinational rotating-priority arbiter.
//   req       : per-requester request
//   ptr       : highest-priority index this cycle
//   enable    : when low no grant is issued
//   grant     : one-hot grant
//   grant_idx : index of the granted requester
//   any_grant : a grant was issued
module vsd_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any_grant
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (enable && !any_grant && req[idx]) begin
            any_grant  = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/vsdserializer_arbiter.sv
// Round-robin scheduler feeding one parallel-in/serial-out serializer.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : arbitration enable (word in flight always completes)
//   req_valid  : per-requester word valid
//   req_data   : packed words, requester i at [i*WORD_W +: WORD_W]
//   req_ready  : one-hot combinational acknowledge
//   ser_load   : one-cycle load strobe to the serializer
//   ser_data   : registered word to the serializer INPUT
//   ser_busy   : serializer emitting a word
//   grant_id   : owner of the current/last word
//   frame_done : pulse in the last bit cycle of a word
//
// state | meaning
// IDLE  | waiting for a valid requester with en=1
// LOAD  | ser_load pulse, first bit cycle
// SHIFT | remaining WORD_W-1 bit cycles; last one may re-arbitrate if no gap
// GAP   | forced idle of GAP_CYCLES cycles, no handshakes
module vsdserializer_arbiter
   import vsdserializer_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int WORD_W     = WORD_W_DEF,
   parameter int GAP_CYCLES = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*WORD_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        ser_load,
   output logic [WORD_W-1:0]           ser_data,
   output logic                        ser_busy,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        frame_done
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CW    = cnt_width(WORD_W, GAP_CYCLES);

   state_t            state_q, state_d;
   logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]     gap_cnt_q, gap_cnt_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              ser_load_q, ser_load_d;
   logic [WORD_W-1:0] ser_data_q, ser_data_d;
   logic              ser_busy_q, ser_busy_d;
   logic [IDX_W-1:0]  grant_id_q, grant_id_d;
   logic              frame_done_q, frame_done_d;

   logic              last_bit;
   logic              win;
   logic              hs;
   logic [IDX_W-1:0]  arb_idx;
   logic [WORD_W-1:0] sel_word;

   assign last_bit = (state_q == ST_SHIFT) && (bit_cnt_q == CW'(WORD_W - 1));
   // Back-to-back re-arbitration on the last bit only when no gap is configured.
   assign win = rst_n && en &&
                ((state_q == ST_IDLE) || (last_bit && (GAP_CYCLES == 0)));

   // The arbiter only grants a valid requester, so any grant is a handshake.
   vsd_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .enable    (win),
      .grant     (req_ready),
      .grant_idx (arb_idx),
      .any_grant (hs)
   );

   always_comb begin
      sel_word = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_idx == IDX_W'(i)) sel_word = req_data[i*WORD_W +: WORD_W];
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      ser_data_d = ser_data_q;
      grant_id_d = grant_id_q;

      case (state_q)
         ST_IDLE: begin
            if (hs) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            state_d   = ST_SHIFT;
            bit_cnt_d = CW'(1);
         end
         ST_SHIFT: begin
            if (last_bit) begin
               if (hs) begin
                  state_d = ST_LOAD;
               end else if (GAP_CYCLES > 0) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == CW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
            else                                  gap_cnt_d = gap_cnt_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (hs) begin
         ser_data_d = sel_word;
         grant_id_d = arb_idx;
         rr_ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
         bit_cnt_d  = '0;
      end

      // Outputs are registered from the next state so they line up with it.
      ser_load_d   = (state_d == ST_LOAD);
      ser_busy_d   = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
      frame_done_d = (state_d == ST_SHIFT) && (bit_cnt_d == CW'(WORD_W - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         rr_ptr_q     <= '0;
         ser_load_q   <= 1'b0;
         ser_data_q   <= '0;
         ser_busy_q   <= 1'b0;
         grant_id_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         rr_ptr_q     <= rr_ptr_d;
         ser_load_q   <= ser_load_d;
         ser_data_q   <= ser_data_d;
         ser_busy_q   <= ser_busy_d;
         grant_id_q   <= grant_id_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign ser_load   = ser_load_q;
   assign ser_data   = ser_data_q;
   assign ser_busy   = ser_busy_q;
   assign grant_id   = grant_id_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vsdserializer_arbiter.sv
// Directed bench for vsdserializer_arbiter: one instance with no gap, one with GAP_CYCLES=3.
module tb_vsdserializer_arbiter;

   localparam int N = 4;
   localparam int W = 10;
   localparam logic [W-1:0] WD0 = 10'h0A1;
   localparam logic [W-1:0] WD1 = 10'h155;
   localparam logic [W-1:0] WD2 = 10'h2B5;
   localparam logic [W-1:0] WD3 = 10'h3C3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n, en;
   logic [N-1:0]   req_valid, req_ready;
   logic [N*W-1:0] req_data;
   logic           ser_load, ser_busy, frame_done;
   logic [W-1:0]   ser_data;
   logic [1:0]     grant_id;

   logic           g_rst_n, g_en;
   logic [N-1:0]   g_valid, g_ready;
   logic           g_load, g_busy, g_fd;
   logic [W-1:0]   g_data;
   logic [1:0]     g_grant;

   assign req_data = {WD3, WD2, WD1, WD0};

   vsdserializer_arbiter #(.NUM_REQ(N), .WORD_W(W), .GAP_CYCLES(0)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .ser_load(ser_load), .ser_data(ser_data),
      .ser_busy(ser_busy), .grant_id(grant_id), .frame_done(frame_done));

   vsdserializer_arbiter #(.NUM_REQ(N), .WORD_W(W), .GAP_CYCLES(3)) dut_g (
      .clk(clk), .rst_n(g_rst_n), .en(g_en), .req_valid(g_valid), .req_data(req_data),
      .req_ready(g_ready), .ser_load(g_load), .ser_data(g_data),
      .ser_busy(g_busy), .grant_id(g_grant), .frame_done(g_fd));

   typedef struct {
      logic [1:0]   id;
      logic [W-1:0] data;
   } exp_t;
   exp_t sb[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_load = 0;
   int prev_load = 0;
   int busy_drops = 0;
   logic mon_busy = 1'b0;
   int lc[3];
   int nl, low, fd_cnt, rdy_seen, load_seen;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (mon_busy && !ser_busy) busy_drops <= busy_drops + 1;

   function automatic logic [W-1:0] word_of(input int i);
      case (i)
         0: return WD0;
         1: return WD1;
         2: return WD2;
         default: return WD3;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int id);
      exp_t e;
      e.id   = 2'(id);
      e.data = word_of(id);
      sb.push_back(e);
   endtask

   task automatic wait_load(input string tag, input int budget);
      int found;
      exp_t e;
      found = 0;
      for (int i = 0; i < budget && found == 0; i++) begin
         @(negedge clk);
         if (ser_load === 1'b1) found = 1;
      end
      chk({tag, " load seen"}, found, 1);
      if (found != 0) begin
         last_load = cyc;
         chk({tag, " sb depth"}, (sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " grant_id"}, grant_id, e.id);
            chk({tag, " ser_data"}, ser_data, e.data);
         end
      end
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int done;
      done = 0;
      for (int i = 0; i < budget && done == 0; i++) begin
         @(negedge clk);
         if (ser_busy === 1'b0) done = 1;
      end
      chk({tag, " idle reached"}, done, 1);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; req_valid = '1;
      g_rst_n = 1'b0; g_en = 1'b1; g_valid = '0;

      // 1: reset with all requesters valid
      repeat (2) @(negedge clk);
      #1;
      chk("t1 ready in reset", req_ready, 4'b0000);
      chk("t1 ser_load", ser_load, 0);
      chk("t1 ser_data", ser_data, 0);
      chk("t1 ser_busy", ser_busy, 0);
      chk("t1 grant_id", grant_id, 0);
      chk("t1 frame_done", frame_done, 0);
      rst_n = 1'b1; g_rst_n = 1'b1;
      #1;
      chk("t1 first ready", req_ready, 4'b0001);
      push(0);
      wait_load("t1", 4);
      req_valid = '0;
      wait_idle("t1", 15);

      // 2: single requester 2, full word timing
      @(negedge clk);
      req_valid = 4'b0100;
      #1;
      chk("t2 ready", req_ready, 4'b0100);
      push(2);
      wait_load("t2", 4);
      req_valid = '0;
      chk("t2 busy k0", ser_busy, 1);
      chk("t2 fd k0", frame_done, 0);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         chk($sformatf("t2 busy k%0d", k), ser_busy, (k <= 9));
         chk($sformatf("t2 fd k%0d", k), frame_done, (k == 9));
         chk($sformatf("t2 data k%0d", k), ser_data, WD2);
         chk($sformatf("t2 load k%0d", k), ser_load, 0);
      end

      // 3: reset pointer, all valid back-to-back
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = '1;
      #1;
      chk("t3 first ready", req_ready, 4'b0001);
      push(0); push(1); push(2); push(3); push(0);
      for (int k = 0; k < 5; k++) begin
         wait_load($sformatf("t3 w%0d", k), 12);
         if (k == 0) mon_busy = 1'b1;
         else chk($sformatf("t3 spacing %0d", k), last_load - prev_load, 10);
         prev_load = last_load;
      end
      mon_busy = 1'b0;
      req_valid = '0;
      chk("t3 busy drops", busy_drops, 0);
      wait_idle("t3", 15);

      // 4: GAP_CYCLES=3 instance, requester 1 always valid
      @(negedge clk);
      g_valid = 4'b0010;
      #1;
      chk("t4 ready", g_ready, 4'b0010);
      nl = 0; low = 0;
      for (int i = 0; i < 60 && nl < 3; i++) begin
         @(negedge clk);
         if (g_load) begin
            chk($sformatf("t4 grant %0d", nl), g_grant, 1);
            chk($sformatf("t4 data %0d", nl), g_data, WD1);
            lc[nl] = cyc;
            nl++;
         end else if (nl == 1 && !g_busy) begin
            low++;
         end
      end
      g_valid = '0;
      chk("t4 loads", nl, 3);
      chk("t4 spacing a", lc[1] - lc[0], 14);
      chk("t4 spacing b", lc[2] - lc[1], 14);
      chk("t4 busy low", low, 4);

      // 5: en falls at bit 4, held 20 cycles
      @(negedge clk);
      req_valid = 4'b0010;
      #1;
      chk("t5 ready", req_ready, 4'b0010);
      push(1);
      wait_load("t5a", 4);
      repeat (4) @(negedge clk);
      en = 1'b0;
      fd_cnt = 0; rdy_seen = 0; load_seen = 0;
      #1;
      for (int i = 0; i < 20; i++) begin
         if (req_ready != '0) rdy_seen++;
         if (frame_done) fd_cnt++;
         if (ser_load) load_seen++;
         @(negedge clk);
      end
      chk("t5 frame_done count", fd_cnt, 1);
      chk("t5 ready while en=0", rdy_seen, 0);
      chk("t5 load while en=0", load_seen, 0);
      en = 1'b1;
      #1;
      chk("t5 ready after en", req_ready, 4'b0010);
      push(1);
      wait_load("t5b", 4);
      req_valid = '0;
      wait_idle("t5", 15);

      // 6: reset mid-word of requester 3
      @(negedge clk);
      req_valid = 4'b1000;
      #1;
      chk("t6 ready", req_ready, 4'b1000);
      push(3);
      wait_load("t6a", 4);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      req_valid = 4'b1001;
      #1;
      chk("t6 ready in reset", req_ready, 4'b0000);
      @(negedge clk);
      chk("t6 ser_load", ser_load, 0);
      chk("t6 ser_data", ser_data, 0);
      chk("t6 ser_busy", ser_busy, 0);
      chk("t6 grant_id", grant_id, 0);
      chk("t6 frame_done", frame_done, 0);
      rst_n = 1'b1;
      #1;
      chk("t6 ready after reset", req_ready, 4'b0001);
      push(0);
      wait_load("t6b", 4);
      req_valid = '0;
      wait_idle("t6", 15);
      chk("sb drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vsdserializer_arbiter.md
Name: vsdserializer_arbiter

Overview:
Round-robin scheduler that shares one vsdserializer_v1 (10-bit parallel-in, serial-out, driven by clk/load/INPUT) between NUM_REQ word producers. It accepts one word per valid/ready handshake and drives the serializer's load strobe and parallel word. It then holds off further loads until all WORD_W bits have shifted out, plus an optional inter-word gap. It sits directly in front of the serializer; ser_load and ser_data connect to its load and INPUT pins.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WORD_W, 10, serializer word width; one bit shifts out per clk
GAP_CYCLES, 0, idle cycles forced between the end of one word and the next arbitration (0..15)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  synchronous, active-low reset
en  input  1  arbitration enable; when low, no new handshakes; the word in flight completes
req_valid  input  NUM_REQ  per-requester word valid
req_data  input  NUM_REQ*WORD_W  packed words; requester i occupies bits [i*WORD_W +: WORD_W]
req_ready  output  NUM_REQ  one-hot handshake acknowledge; the word transfers when valid[i]&ready[i]
ser_load  output  1  serializer load strobe, one-cycle pulse
ser_data  output  WORD_W  registered word presented to serializer INPUT
ser_busy  output  1  high while the serializer is emitting a word (LOAD and SHIFT states)
grant_id  output  clog2(NUM_REQ)  index of the requester owning the word in flight; holds its value after completion
frame_done  output  1  one-cycle pulse in the last bit cycle of each word

Behaviour:
- States: IDLE, LOAD, SHIFT, GAP. The state is registered.
- Reset (rst_n low at an edge, in any state, including mid-word): state=IDLE, ser_load=0, ser_data=0, ser_busy=0, grant_id=0, frame_done=0, bit_cnt=0, gap_cnt=0, rr_ptr=0. req_ready is forced to 0 combinationally while rst_n=0. A word in flight is dropped and not re-issued.
- Arbitration window (win) is true in two cases:
  - state IDLE;
  - state SHIFT with bit_cnt==WORD_W-1 and GAP_CYCLES==0.
- Window gating: win is qualified by en=1 and rst_n=1.
- Grant selection: the first valid requester searching from rr_ptr upward, modulo NUM_REQ.
- req_ready is combinational: one-hot at the granted index during win, otherwise all zero. ready may depend on valid; requesters must not make valid depend on ready.
- On handshake: ser_data<=req_data[g], grant_id<=g, rr_ptr<=(g+1) mod NUM_REQ, next state=LOAD.
- LOAD (1 cycle): ser_load=1, ser_busy=1, bit_cnt<=1, next state=SHIFT.
- SHIFT: ser_busy=1, bit_cnt increments each cycle. When bit_cnt==WORD_W-1, frame_done=1 and the next state is:
  - LOAD, if a handshake occurs in that cycle;
  - GAP, if GAP_CYCLES>0;
  - IDLE, otherwise.
- Word occupancy is LOAD plus WORD_W-1 SHIFT cycles, i.e. WORD_W cycles. ser_data is stable throughout.
- GAP: ser_busy=0, counts GAP_CYCLES cycles, then goes to IDLE. No handshake in GAP.
- IDLE with no valid requester, or en=0: remain in IDLE, all outputs idle, ser_data holds its last word.
- Latency: a handshake in IDLE gives ser_load in the next cycle.
- Throughput, GAP_CYCLES=0 with continuous requests: one load every WORD_W cycles, back-to-back.
- Throughput, GAP_CYCLES=G: load spacing is WORD_W+G+1 cycles.
- en falling mid-word: the current word completes normally, then the block stays in IDLE until en=1.
- valid dropping before ready: no transfer. rr_ptr only changes on a handshake.

Decomposition:
- Package vsdserializer_pkg:
  - state enum (IDLE/LOAD/SHIFT/GAP);
  - default WORD_W=10;
  - function computing the counter width from WORD_W and GAP_CYCLES.
- Sub-module vsd_rr_arbiter: combinational rotating-priority grant. Inputs req[NUM_REQ], ptr, enable; outputs one-hot grant, grant index, any_grant. The top holds the FSM, counters and data register.

Test Plan:
1. rst_n low 2 cycles, all req_valid=1 -> all outputs 0, req_ready=0 during reset; first handshake to requester 0 in the first cycle after release.
2. Only req 2 valid, data 10'h2B5 -> req_ready[2] the same cycle; ser_load next cycle with ser_data=10'h2B5, grant_id=2; ser_busy for 10 cycles; frame_done on the 10th; serializer output bit sequence matches 10'h2B5.
3. All 4 valid continuously, GAP_CYCLES=0 -> grant order 0,1,2,3,0; ser_load every 10 cycles; ser_busy never drops.
4. GAP_CYCLES=3, req 1 always valid -> ser_load spacing 14 cycles; ser_busy low for 4 cycles between words.
5. en driven low at bit 4 of a word, held 20 cycles -> the word finishes with frame_done; no req_ready while en=0; next handshake in the first cycle after en=1.
6. rst_n low for 1 cycle at bit 5 of requester 3's word -> next cycle IDLE, all outputs 0, rr_ptr=0; after release, pending requesters 0 and 3 -> requester 0 granted first.
